// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional FETCH_BUBBLE_CNT_EN adds a saturating count of bubble cycles in IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op,
`ifdef FETCH_BUBBLE_CNT_EN
  output logic [5:0]  func,
  output logic [31:0] bubble_cnt
`else
  output logic [5:0]  func
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        redirect;
  if_id_t      if_id_q, if_id_d;

  always_comb begin
    pc4      = pc_q + 32'd4;
    redirect = 1'b0;
    next_pc  = pc4;
    unique case (pc_src)
      2'b01: begin
        next_pc  = branch_target;
        redirect = 1'b1;
      end
      2'b10: begin
        next_pc  = {if_id_q.pc4[31:28], jump_index, 2'b00};
        redirect = 1'b1;
      end
      default: next_pc = pc4;
    endcase
  end

  // A redirect must not be lost while decode is stalled.
  always_comb begin
    pc_d = next_pc;
    if (stall && !redirect) pc_d = pc_q;
  end

  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = BUBBLE;
    end else if (!stall) begin
      if_id_d = '{instr: imem_data, pc4: pc4, valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= BUBBLE;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign op          = if_id_q.instr[31:26];
  assign func        = if_id_q.instr[5:0];

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!if_id_q.valid && bubble_cnt_q != 32'hFFFF_FFFF)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_cnt_q <= 32'h0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns the bitwise inverse of the address.
// Build with FETCH_BUBBLE_CNT_EN defined to also check the bubble counter.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op, func;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = ~imem_addr;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .pc_src(pc_src),
    .branch_target(branch_target),
    .jump_index(jump_index),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid),
    .op(op),
`ifdef FETCH_BUBBLE_CNT_EN
    .func(func),
    .bubble_cnt(bubble_cnt)
`else
    .func(func)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
    chk({tag, "_instr"}, if_id_instr, instr);
    chk({tag, "_pc4"}, if_id_pc4, pc4);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, valid});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    branch_target = 32'h0; jump_index = 26'h0;
    tick();
    tick();
    chk("rst_addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_op", {26'b0, op}, 32'h0);
    chk("rst_func", {26'b0, func}, 32'h0);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("rst_bcnt", bubble_cnt, 32'h0);
`endif

    rst = 1'b0;
    tick();
    chk("seq1_addr", imem_addr, 32'h4);
    chk_ifid("seq1", ~32'h0, 32'h4, 1'b1);
    tick();
    chk("seq2_addr", imem_addr, 32'h8);
    chk_ifid("seq2", ~32'h4, 32'h8, 1'b1);
    tick();
    tick();
    chk("seq4_addr", imem_addr, 32'h10);
    chk_ifid("seq4", ~32'hC, 32'h10, 1'b1);
    chk("op_ones", {26'b0, op}, 32'h3F);
    chk("func_f3", {26'b0, func}, 32'h33);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h10);
      chk_ifid("stall", ~32'hC, 32'h10, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_addr", imem_addr, 32'h14);
    chk_ifid("unstall", ~32'h10, 32'h14, 1'b1);
    tick();
    chk("pre_br_addr", imem_addr, 32'h18);

    pc_src = 2'b01; branch_target = 32'h40; flush = 1'b1;
    tick();
    chk("br_addr", imem_addr, 32'h40);
    chk_ifid("br_bubble", 32'h0, 32'h0, 1'b0);
    chk("br_op", {26'b0, op}, 32'h0);
    chk("br_func", {26'b0, func}, 32'h0);
    pc_src = 2'b00; flush = 1'b0;
    tick();
    chk("br_tgt_addr", imem_addr, 32'h44);
    chk_ifid("br_tgt", ~32'h40, 32'h44, 1'b1);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("bcnt_after_br", bubble_cnt, 32'h2);
`endif

    stall = 1'b1; pc_src = 2'b01; branch_target = 32'h8000_0004;
    tick();
    chk("redir_stall_addr", imem_addr, 32'h8000_0004);
    chk_ifid("redir_stall", ~32'h40, 32'h44, 1'b1);
    stall = 1'b0; pc_src = 2'b00;
    tick();
    chk("hi_addr", imem_addr, 32'h8000_0008);
    chk_ifid("hi", ~32'h8000_0004, 32'h8000_0008, 1'b1);

    pc_src = 2'b10; jump_index = 26'h000_0010;
    tick();
    chk("jmp_addr", imem_addr, 32'h8000_0040);
    chk_ifid("jmp", ~32'h8000_0008, 32'h8000_000C, 1'b1);

    pc_src = 2'b01; branch_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    pc_src = 2'b00;
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk_ifid("wrap", ~32'hFFFF_FFFC, 32'h0, 1'b1);

    pc_src = 2'b11; branch_target = 32'h200;
    tick();
    chk("rsvd_addr", imem_addr, 32'h4);
    chk_ifid("rsvd", ~32'h0, 32'h4, 1'b1);

    pc_src = 2'b00; stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_stall_addr", imem_addr, 32'h4);
    chk_ifid("flush_stall", 32'h0, 32'h0, 1'b0);

    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    pc_src = 2'b01; branch_target = 32'h100;
    tick();
    chk("rst_mid_addr", imem_addr, 32'h0);
    chk_ifid("rst_mid", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("rst_mid_bcnt", bubble_cnt, 32'h0);
`endif
    rst = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    tick();
    chk("post_rst_addr", imem_addr, 32'h4);
    chk_ifid("post_rst", ~32'h0, 32'h4, 1'b1);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("post_rst_bcnt", bubble_cnt, 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
